// File: rtl/fruit_control_pkg.sv
// ============================================================================
// fruit_control_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the fruit sequencer and the fruit datapath: FSM state
// encoding and screen/sprite geometry constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fruit_control_pkg;

  localparam int SCREEN_H         = 120;
  localparam int SPRITE_PX        = 16;
  // Top-row y at which a 16-px sprite touches the bottom of the screen.
  localparam int BOTTOM_Y_DEFAULT = SCREEN_H - SPRITE_PX;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_NEW       = 3'd1,
    S_DRAW      = 3'd2,
    S_WAIT      = 3'd3,
    S_ERASE     = 3'd4,
    S_MOVE      = 3'd5,
    S_CHECK     = 3'd6,
    S_GAME_OVER = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fruit_frame_counter.sv
// ============================================================================
// fruit_frame_counter
// ----------------------------------------------------------------------------
// Counts frame ticks and flags the tick that completes FRAMES_PER_STEP frames.
// Ports:
//   clock, resetn  - clock, synchronous active-low reset
//   clear          - synchronous clear of the count
//   tick           - qualified frame tick
//   terminal       - high on the tick that completes the step
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fruit_frame_counter #(
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic tick,
  output logic terminal
);

  localparam int CW = 4;

  logic [CW-1:0] frame_cnt;

  assign terminal = tick && (frame_cnt == CW'(FRAMES_PER_STEP - 1));

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      frame_cnt <= '0;
    end else if (terminal) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fruit_control.sv
// ============================================================================
// fruit_control
// ----------------------------------------------------------------------------
// Sequencing FSM for the fruit datapath: spawn, draw, wait frames, erase, step
// down, then resolve cut/miss. Keeps the cut score and the lives counter.
// Ports:
//   clock, resetn          - clock, synchronous active-low reset
//   start                  - level, starts a game from IDLE / GAME_OVER
//   frame_tick             - one pulse per video frame
//   cut                    - blade touched the current fruit (pulse)
//   fruit_drawn            - datapath sprite sweep complete
//   fruit_y_position[6:0]  - datapath fruit top-row y
//   new_fruit, draw_fruit, move_fruit, erase - datapath strobes
//   plot                   - VGA write enable
//   number_of_fruits_cut   - saturating score
//   lives                  - remaining lives
//   game_over              - high in GAME_OVER
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fruit_control
  import fruit_control_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int BOTTOM_Y        = BOTTOM_Y_DEFAULT,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       cut,
  input  logic       fruit_drawn,
  input  logic [6:0] fruit_y_position,
  output logic       new_fruit,
  output logic       draw_fruit,
  output logic       move_fruit,
  output logic       erase,
  output logic       plot,
  output logic [7:0] number_of_fruits_cut,
  output logic [2:0] lives,
  output logic       game_over
);

  state_t     state;
  state_t     next_state;
  logic       cut_latched;
  logic [6:0] y_prev;
  logic       step_done;
  logic       miss;
  logic       cut_window;

  fruit_frame_counter #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_frame_counter (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (state == S_NEW),
    .tick     (frame_tick && (state == S_WAIT)),
    .terminal (step_done)
  );

  // A y that went backwards means the step wrapped past 127: off-screen.
  assign miss = (fruit_y_position >= 7'(BOTTOM_Y)) || (fruit_y_position < y_prev);

  assign cut_window = (state == S_DRAW) || (state == S_WAIT) ||
                      (state == S_ERASE) || (state == S_MOVE);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_NEW;
      S_NEW:       next_state = S_DRAW;
      S_DRAW:      if (fruit_drawn) next_state = S_WAIT;
      S_WAIT:      if (step_done) next_state = S_ERASE;
      S_ERASE:     if (fruit_drawn) next_state = S_MOVE;
      S_MOVE:      next_state = S_CHECK;
      S_CHECK: begin
        if (cut_latched)     next_state = S_NEW;
        else if (miss)       next_state = (lives <= 3'd1) ? S_GAME_OVER : S_NEW;
        else                 next_state = S_DRAW;
      end
      S_GAME_OVER: if (start) next_state = S_NEW;
      default:     next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from next_state so they line up with the state
  // register and never depend combinationally on inputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state                <= S_IDLE;
      new_fruit            <= 1'b0;
      draw_fruit           <= 1'b0;
      move_fruit           <= 1'b0;
      erase                <= 1'b0;
      plot                 <= 1'b0;
      game_over            <= 1'b0;
      number_of_fruits_cut <= 8'd0;
      lives                <= 3'(LIVES);
      cut_latched          <= 1'b0;
      y_prev               <= 7'd0;
    end else begin
      state      <= next_state;
      new_fruit  <= (next_state == S_NEW);
      draw_fruit <= (next_state == S_DRAW) || (next_state == S_ERASE);
      erase      <= (next_state == S_ERASE);
      move_fruit <= (next_state == S_MOVE);
      game_over  <= (next_state == S_GAME_OVER);
      // One cycle late to match the datapath's registered pixel coordinates.
      plot       <= draw_fruit & ~fruit_drawn;

      if (((state == S_IDLE) || (state == S_GAME_OVER)) && start) begin
        number_of_fruits_cut <= 8'd0;
        lives                <= 3'(LIVES);
      end

      if (state == S_NEW) begin
        cut_latched <= 1'b0;
      end else if (cut && cut_window) begin
        cut_latched <= 1'b1;
      end

      if (state == S_MOVE) begin
        y_prev <= fruit_y_position;
      end

      if (state == S_CHECK) begin
        if (cut_latched) begin
          if (number_of_fruits_cut != 8'hFF) begin
            number_of_fruits_cut <= number_of_fruits_cut + 8'd1;
          end
        end else if (miss) begin
          lives <= lives - 3'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fruit_control.md
# fruit_control

Sequencing FSM for the fruit datapath: spawns a fruit, draws it, waits on the frame tick, erases it, steps it down, then resolves cut/miss.
- Maintains the cut score, which feeds the datapath's speed selection.
- Maintains a lives counter and raises game-over.
- Sits between the top-level game FSM (start/frame tick/blade hit) and the fruit datapath plus VGA adapter.

## Interface
Parameters:
- LIVES, 3: misses allowed before game over (1..7).
- BOTTOM_Y, 104: fruit top-row y at or beyond which the fruit is missed (screen height 120 minus 16-px sprite).
- FRAMES_PER_STEP, 1: frame ticks to wait between draw and erase (1..15).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  level; starts or restarts a game from IDLE or GAME_OVER.
- frame_tick  in  1  one-cycle pulse per video frame.
- cut  in  1  one-cycle pulse from hit detection: blade touched the current fruit.
- fruit_drawn  in  1  datapath: sprite sweep complete.
- fruit_y_position  in  7  datapath: current fruit top-row y.
- new_fruit  out  1  datapath: spawn fruit at random x, y=0.
- draw_fruit  out  1  datapath: run sprite sweep (used for both draw and erase).
- move_fruit  out  1  datapath: apply one speed step.
- erase  out  1  colour mux select; 1 forces black while sweeping.
- plot  out  1  VGA write enable.
- number_of_fruits_cut  out  8  score; saturates at 255.
- lives  out  3  remaining lives.
- game_over  out  1  high in GAME_OVER.

## Operation
States and transitions:
- IDLE: wait for start, then go to NEW.
- NEW: 1 cycle, new_fruit=1; clear cut_latched and frame_cnt.
- DRAW: draw_fruit=1, erase=0 until fruit_drawn=1, then go to WAIT.
- WAIT: all datapath strobes 0. Each frame_tick increments frame_cnt; when frame_cnt reaches FRAMES_PER_STEP-1 on a tick, clear frame_cnt and go to ERASE.
- ERASE: draw_fruit=1, erase=1 until fruit_drawn=1, then go to MOVE.
- MOVE: 1 cycle, move_fruit=1; capture y_prev ← fruit_y_position (the pre-move value).
- CHECK: 1 cycle, evaluated on the updated y.
  - cut_latched: number_of_fruits_cut increments, saturating at 255; go to NEW.
  - Otherwise a miss if fruit_y_position ≥ BOTTOM_Y or fruit_y_position < y_prev (7-bit wrap). On a miss, lives decrements. If lives was 1, go to GAME_OVER; else go to NEW.
  - Otherwise go to DRAW.
- GAME_OVER: game_over=1, all strobes 0. start goes to NEW with score cleared and lives=LIVES.

Cut handling:
- cut_latched sets on any cut pulse in DRAW, WAIT, ERASE or MOVE, and holds until NEW.
- cut in IDLE, NEW, CHECK or GAME_OVER is ignored.

Other rules:
- Between any two sweeps, draw_fruit is low for at least 1 cycle so the datapath clears its sweep counter. WAIT and MOVE guarantee this.
- start from IDLE also clears score and sets lives=LIVES.
- start while in any playing state is ignored.

## Timing
- Reset values: state=IDLE; new_fruit, draw_fruit, move_fruit, erase, plot, game_over = 0; number_of_fruits_cut=0; lives=LIVES; cut_latched=0; frame_cnt=0; y_prev=0.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.
- plot is draw_fruit & ~fruit_drawn, registered 1 cycle to align with the datapath's registered fruit_x_out and fruit_y_out.
- Latency:
  - start to new_fruit: 1 cycle.
  - fruit_drawn to leaving DRAW or ERASE: 1 cycle.
  - Tick qualifying in WAIT to erase=1: 1 cycle.
  - MOVE to CHECK: 1 cycle. Total MOVE→CHECK→NEW/DRAW: 2 cycles.
- Simultaneous events:
  - cut and miss in the same step: cut wins; no life is lost.
  - cut in the same cycle as the MOVE strobe is latched.
  - frame_tick outside WAIT is ignored.
- Reset asserted mid-sweep returns to IDLE on the next edge. The datapath resets on the same edge.

## Structure
- Shared package: state encoding (8 states, 3-bit), plus constants SCREEN_H=120, SPRITE_PX=16 and BOTTOM_Y default.
- The datapath uses the same constants.
- One natural sub-module, fruit_frame_counter: counts frame ticks against FRAMES_PER_STEP, with clear and a terminal-count output.
- Everything else is a single FSM plus score/lives registers.

## Test plan
- Reset then start, with a datapath model giving fruit_drawn after 256 cycles. Required: new_fruit 1 cycle, DRAW for 256 cycles with plot high 256 cycles, WAIT with strobes 0, erase=1 after frame_tick, then move_fruit 1 cycle.
- cut pulse during WAIT with score 3. Required: CHECK → NEW; number_of_fruits_cut=4; lives unchanged; cut_latched cleared in NEW.
- y stepped 96→110 (≥104), no cut, lives=3. Required: lives=2, next state NEW. Repeat twice more: lives=0, game_over=1, and no strobes until start.
- y wraps 120→5 (step +13 modulo 128). Required: counted as a miss even though 5 < BOTTOM_Y.
- Score at 255 plus a cut. Required: stays 255. Also, cut coincident with y ≥ BOTTOM_Y: score +1 and no life lost.
- resetn low mid-ERASE, and start during DRAW. Required: reset returns all outputs to reset values next edge; start during DRAW has no effect.
